// File: rtl/dm_arbiter_if.sv
// Handshake bundle between one requester and dm_arbiter.
// The requester is the master; the arbiter is the slave.
interface dm_arbiter_if;
  logic        req;
  logic        we;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port 1024 x 32 data memory.
// Port 0 is the CPU data port and port 1 is the loader/DMA/debug port.
// Every access runs IDLE -> ACCESS -> RESP. Arbitration is round-robin
// by default. With FIXED_PRIO=1, port 0 always wins a tie.
module dm_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  dm_arbiter_if.slave m0,
  dm_arbiter_if.slave m1,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   sel;
  logic   sel_nxt;
  logic   last;
  logic   sel_we;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grant decision. A grant is only taken in IDLE, so
  // requests that arrive during ACCESS/RESP wait for the next IDLE.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    unique case (state)
      IDLE: begin
        if (m0.req || m1.req) begin
          state_nxt = ACCESS;
          if (m0.req && m1.req) begin
            sel_nxt = FIXED_PRIO ? 1'b0 : ~last;
          end else begin
            sel_nxt = m1.req;
          end
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, round-robin history, ack pulses and read data capture.
  // The ack is registered at the closing edge of ACCESS, so it is high
  // for exactly the RESP cycle. Reads capture the combinational memory
  // output at that same edge. Writes leave rdata untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= 1'b0;
      last     <= 1'b1;
      m0.ack   <= 1'b0;
      m1.ack   <= 1'b0;
      m0.rdata <= 32'h0;
      m1.rdata <= 32'h0;
    end else begin
      sel    <= sel_nxt;
      m0.ack <= (state == ACCESS) && !sel;
      m1.ack <= (state == ACCESS) && sel;
      if (state == ACCESS) begin
        last <= sel;
        if (!sel && !m0.we) begin
          m0.rdata <= dm_dout;
        end
        if (sel && !m1.we) begin
          m1.rdata <= dm_dout;
        end
      end
    end
  end

  // Memory-side drive. Address and data always follow the selected
  // port, so they never float. The write enable is only active in
  // ACCESS, and it is killed while reset is high so that a reset edge
  // cannot commit a write.
  always_comb begin
    dm_addr = sel ? m1.addr  : m0.addr;
    dm_din  = sel ? m1.wdata : m0.wdata;
    sel_we  = sel ? m1.we    : m0.we;
    dm_we   = (state == ACCESS) && sel_we && !rst;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter. It runs a round-robin instance (index 0) and a
// fixed-priority instance (index 1) side by side. Each instance has its
// own memory and requesters, and a transaction-level reference model.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_arbiter_if ia0 ();
  dm_arbiter_if ia1 ();
  dm_arbiter_if ib0 ();
  dm_arbiter_if ib1 ();

  // Requester drive, indexed [instance][port].
  logic        r_req   [2][2];
  logic        r_we    [2][2];
  logic [9:0]  r_addr  [2][2];
  logic [31:0] r_wdata [2][2];
  logic        r_hold  [2][2];

  logic        o_ack   [2][2];
  logic [31:0] o_rdata [2][2];

  logic [9:0]  dm_addr [2];
  logic [31:0] dm_din  [2];
  logic        dm_we   [2];
  logic [31:0] dm_dout [2];
  logic        busy    [2];

  assign ia0.req = r_req[0][0];  assign ia0.we = r_we[0][0];
  assign ia0.addr = r_addr[0][0]; assign ia0.wdata = r_wdata[0][0];
  assign ia1.req = r_req[0][1];  assign ia1.we = r_we[0][1];
  assign ia1.addr = r_addr[0][1]; assign ia1.wdata = r_wdata[0][1];
  assign ib0.req = r_req[1][0];  assign ib0.we = r_we[1][0];
  assign ib0.addr = r_addr[1][0]; assign ib0.wdata = r_wdata[1][0];
  assign ib1.req = r_req[1][1];  assign ib1.we = r_we[1][1];
  assign ib1.addr = r_addr[1][1]; assign ib1.wdata = r_wdata[1][1];

  assign o_ack[0][0] = ia0.ack;  assign o_rdata[0][0] = ia0.rdata;
  assign o_ack[0][1] = ia1.ack;  assign o_rdata[0][1] = ia1.rdata;
  assign o_ack[1][0] = ib0.ack;  assign o_rdata[1][0] = ib0.rdata;
  assign o_ack[1][1] = ib1.ack;  assign o_rdata[1][1] = ib1.rdata;

  dm_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst(rst), .m0(ia0), .m1(ia1),
    .dm_addr(dm_addr[0]), .dm_din(dm_din[0]), .dm_we(dm_we[0]),
    .dm_dout(dm_dout[0]), .busy(busy[0])
  );

  dm_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .m0(ib0), .m1(ib1),
    .dm_addr(dm_addr[1]), .dm_din(dm_din[1]), .dm_we(dm_we[1]),
    .dm_dout(dm_dout[1]), .busy(busy[1])
  );

  // Data memories: combinational read and a write at the rising edge.
  logic [31:0] mem [2][1024];
  logic        clear_mem;

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 1024; i++) mem[d][i] = 32'h0;
    end else begin
      for (int d = 0; d < 2; d++)
        if (dm_we[d]) mem[d][dm_addr[d]] = dm_din[d];
    end
  end

  assign dm_dout[0] = mem[0][dm_addr[0]];
  assign dm_dout[1] = mem[1][dm_addr[1]];

  // Reference model. A grant opens a 3-edge window that starts at edge
  // e0: busy after e0 and e0+1, memory effect and ack at e0+1, and the
  // next grant no earlier than e0+3.
  int          edge_n;
  int          m_free  [2];
  int          m_e0    [2];
  logic        m_last  [2];
  logic        m_win   [2];
  logic        m_we    [2];
  logic [9:0]  m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2][2];
  logic [31:0] m_mem   [2][1024];

  // Acks seen on the DUT: port and edge number.
  int   acnt  [2];
  logic aport [2][16];
  int   aedge [2][16];

  logic random_mode;
  int   vectors;
  int   fails;

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(int d, int p, logic we, logic [9:0] addr, logic [31:0] wdata);
    r_req[d][p]   = 1'b1;
    r_we[d][p]    = we;
    r_addr[d][p]  = addr;
    r_wdata[d][p] = wdata;
  endtask

  task automatic clear_log();
    for (int d = 0; d < 2; d++) begin
      acnt[d] = 0;
      for (int k = 0; k < 16; k++) begin
        aport[d][k] = 1'b0;
        aedge[d][k] = 0;
      end
    end
  endtask

  // One clock edge. The model is advanced for the upcoming edge, then
  // every output is compared, and then the requesters react to acks.
  task automatic step();
    int n;
    n = edge_n + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_free[d] = n + 1;
        m_e0[d]   = -100;
        m_last[d] = 1'b1;
        m_rdata[d][0] = 32'h0;
        m_rdata[d][1] = 32'h0;
      end else begin
        if (n == m_e0[d] + 1) begin
          if (m_we[d]) m_mem[d][m_addr[d]] = m_wdata[d];
          else         m_rdata[d][m_win[d]] = m_mem[d][m_addr[d]];
        end
        if (n >= m_free[d] && (r_req[d][0] || r_req[d][1])) begin
          if (r_req[d][0] && r_req[d][1])
            m_win[d] = (d == 1) ? 1'b0 : ~m_last[d];
          else
            m_win[d] = r_req[d][1];
          m_last[d]  = m_win[d];
          m_e0[d]    = n;
          m_free[d]  = n + 3;
          m_we[d]    = r_we[d][m_win[d]];
          m_addr[d]  = r_addr[d][m_win[d]];
          m_wdata[d] = r_wdata[d][m_win[d]];
        end
      end
    end

    @(posedge clk);
    #1;
    edge_n = n;

    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("busy[%0d]@%0d", d, n), {31'b0, busy[d]},
                   {31'b0, (m_e0[d] == n) || (m_e0[d] + 1 == n)});
      check_output($sformatf("dm_we[%0d]@%0d", d, n), {31'b0, dm_we[d]},
                   {31'b0, (m_e0[d] == n) && m_we[d] && !rst});
      if (m_e0[d] == n) begin
        check_output($sformatf("dm_addr[%0d]@%0d", d, n), {22'b0, dm_addr[d]}, {22'b0, m_addr[d]});
        if (m_we[d])
          check_output($sformatf("dm_din[%0d]@%0d", d, n), dm_din[d], m_wdata[d]);
      end
      for (int p = 0; p < 2; p++) begin
        check_output($sformatf("ack[%0d][%0d]@%0d", d, p, n), {31'b0, o_ack[d][p]},
                     {31'b0, (m_e0[d] + 1 == n) && (m_win[d] == p[0])});
        check_output($sformatf("rdata[%0d][%0d]@%0d", d, p, n), o_rdata[d][p], m_rdata[d][p]);
        if (o_ack[d][p] === 1'b1 && acnt[d] < 16) begin
          aport[d][acnt[d]] = p[0];
          aedge[d][acnt[d]] = n;
          acnt[d]++;
        end
      end
    end

    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if ((m_e0[d] + 1 == n) && (m_win[d] == p[0])) begin
          if (random_mode) begin
            if ($urandom_range(0, 1) == 1)
              apply_stimulus(d, p, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
            else
              r_req[d][p] = 1'b0;
          end else if (!r_hold[d][p]) begin
            r_req[d][p] = 1'b0;
          end
        end else if (random_mode && !r_req[d][p] && $urandom_range(0, 2) == 0) begin
          apply_stimulus(d, p, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    fails       = 0;
    edge_n      = 0;
    random_mode = 1'b0;
    clear_mem   = 1'b1;
    rst         = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_free[d] = 0;
      m_e0[d]   = -100;
      m_last[d] = 1'b1;
      m_win[d]  = 1'b0;
      m_we[d]   = 1'b0;
      m_addr[d] = 10'h0;
      m_wdata[d] = 32'h0;
      for (int p = 0; p < 2; p++) begin
        r_req[d][p] = 1'b0;  r_we[d][p] = 1'b0;  r_hold[d][p] = 1'b0;
        r_addr[d][p] = 10'h0; r_wdata[d][p] = 32'h0;
        m_rdata[d][p] = 32'h0;
      end
      for (int i = 0; i < 1024; i++) m_mem[d][i] = 32'h0;
    end
    clear_log();

    // Reset state.
    step();
    clear_mem = 1'b0;
    step();
    rst = 1'b0;

    // Port 0 writes DEADBEEF to word 3.
    for (int d = 0; d < 2; d++) apply_stimulus(d, 0, 1'b1, 10'h003, 32'hDEADBEEF);
    repeat (5) step();
    for (int d = 0; d < 2; d++)
      check_output($sformatf("mem3[%0d]", d), mem[d][3], 32'hDEADBEEF);

    // Port 1 reads word 3 back.
    for (int d = 0; d < 2; d++) apply_stimulus(d, 1, 1'b0, 10'h003, 32'h0);
    repeat (5) step();
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("m1_rdata_rd3[%0d]", d), o_rdata[d][1], 32'hDEADBEEF);
      check_output($sformatf("m0_rdata_kept[%0d]", d), o_rdata[d][0], 32'h0);
    end

    // Both ports hold their requests from reset onward.
    rst = 1'b1;
    clear_log();
    for (int d = 0; d < 2; d++) begin
      apply_stimulus(d, 0, 1'b1, 10'h001, 32'h11111111);
      apply_stimulus(d, 1, 1'b1, 10'h002, 32'h22222222);
      r_hold[d][0] = 1'b1;
      r_hold[d][1] = 1'b1;
    end
    step();
    rst = 1'b0;
    repeat (12) step();
    check_output("rr_ack_count", acnt[0], 4);
    check_output("fp_ack_count", acnt[1], 4);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("rr_order%0d", k), {31'b0, aport[0][k]}, k % 2);
      check_output($sformatf("fp_order%0d", k), {31'b0, aport[1][k]}, 0);
    end
    check_output("rr_ack_spacing", aedge[0][1] - aedge[0][0], 3);
    for (int d = 0; d < 2; d++) begin
      r_hold[d][0] = 1'b0;
      r_hold[d][1] = 1'b0;
    end
    repeat (9) step();
    check_output("fp_ack_count_drain", acnt[1], 6);
    check_output("fp_m1_after_drop", {31'b0, aport[1][5]}, 1);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("mem1[%0d]", d), mem[d][1], 32'h11111111);
      check_output($sformatf("mem2[%0d]", d), mem[d][2], 32'h22222222);
    end

    // Reset lands while a port 0 write is in ACCESS.
    for (int d = 0; d < 2; d++) apply_stimulus(d, 0, 1'b1, 10'h00A, 32'h12345678);
    step();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) r_req[d][0] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      check_output($sformatf("we_in_rst[%0d]", d), {31'b0, dm_we[d]}, 0);
    step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("busy_after_rst[%0d]", d), {31'b0, busy[d]}, 0);
      check_output($sformatf("m1_rdata_rst[%0d]", d), o_rdata[d][1], 32'h0);
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++)
      check_output($sformatf("memA[%0d]", d), mem[d][10], 32'h0);

    // Port 1 raises req during the RESP cycle of a port 0 read.
    clear_log();
    for (int d = 0; d < 2; d++) apply_stimulus(d, 0, 1'b0, 10'h001, 32'h0);
    step();
    step();
    for (int d = 0; d < 2; d++) apply_stimulus(d, 1, 1'b1, 10'h005, 32'hCAFEF00D);
    repeat (6) step();
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("late_ack_count[%0d]", d), acnt[d], 2);
      check_output($sformatf("late_order[%0d]", d), {30'b0, aport[d][0], aport[d][1]}, 32'h1);
      check_output($sformatf("late_spacing[%0d]", d), aedge[d][1] - aedge[d][0], 3);
      check_output($sformatf("m0_rdata_rd1[%0d]", d), o_rdata[d][0], 32'h11111111);
      check_output($sformatf("mem5[%0d]", d), mem[d][5], 32'hCAFEF00D);
    end

    // Random traffic on both instances, then drain.
    random_mode = 1'b1;
    repeat (600) step();
    random_mode = 1'b0;
    repeat (12) step();
    for (int d = 0; d < 2; d++) begin
      int bad;
      bad = 0;
      for (int i = 0; i < 1024; i++)
        if (mem[d][i] !== m_mem[d][i]) bad++;
      check_output($sformatf("mem_image[%0d]", d), bad, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter that shares the single-port 4 KiB data memory (1024 x 32, word addressed by addr[11:2]) between requester 0 (CPU data port) and requester 1 (loader/DMA/debug port).
- Sits directly in front of the data memory and owns its addr/din/write-enable inputs.
- Consumes the memory's combinational read output.
- Sequences each access as a 3-state transaction with a req/ack handshake, and supports round-robin or fixed-priority arbitration.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins simultaneous requests.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- m0_req  in  1  port 0 request; held high with fields stable until m0_ack seen
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  10  port 0 word address [11:2]
- m0_wdata  in  32  port 0 write data
- m0_ack  out  1  port 0 one-cycle completion pulse
- m0_rdata  out  32  port 0 registered read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as port 0, for port 1
- dm_addr  out  10  to memory addr[11:2]
- dm_din  out  32  to memory write data
- dm_we  out  1  to memory write enable
- dm_dout  in  32  memory combinational read data
- busy  out  1  high in ACCESS or RESP

Behaviour:
- Reset (rst sampled high at an edge):
  - state=IDLE, last=1 (port 0 wins first contest), sel=0.
  - m0_ack=m1_ack=0; m0_rdata=m1_rdata=0.
  - dm_we is forced 0 combinationally whenever rst=1, so no write commits during a reset edge, even from ACCESS.
- State machine:
  - IDLE: if neither req is high, stay in IDLE.
    - If exactly one req is high: sel<=that port, go to ACCESS.
    - If both are high and FIXED_PRIO=1: sel<=0.
    - If both are high and FIXED_PRIO=0: sel<=~last.
  - ACCESS (exactly 1 cycle):
    - dm_addr and dm_din come from port sel; dm_we = sel port's we.
    - At the closing edge, a write commits in memory; a read captures dm_dout into msel_rdata.
    - The same edge sets msel_ack<=1, last<=sel, and moves to RESP.
  - RESP (1 cycle): msel_ack=1 and the requests are ignored. Next edge clears ack and moves to IDLE.
- Latency and throughput:
  - req high before edge E0 → ACCESS in the cycle after E0 → ack high in the cycle after E0+1 → IDLE after E0+2.
  - 3 cycles per transaction; a continuously requesting pair alternates under round-robin.
- Requester rules:
  - The requester must drop req in the cycle after it sees ack, or issue a new transaction by keeping req high; a held req is re-arbitrated in IDLE.
  - Fields sampled during ACCESS are the only ones used.
- rdata behaviour:
  - rdata updates only on a completed read of that port.
  - It holds its value otherwise; writes leave rdata unchanged.
- Outputs outside ACCESS:
  - dm_we=0.
  - dm_addr and dm_din are driven from port sel, so they are deterministic and not X.
- A req that goes high during ACCESS or RESP is not lost; it is served from the next IDLE.
- Reset during ACCESS or RESP: the transaction is abandoned, with no write, no ack and rdata cleared to 0.
- busy = (state != IDLE).
- No combinational path from req to ack; ack and rdata are registers.

Test Plan:
- Reset, then m0 writes addr 0x003 with 0xDEADBEEF → dm_we=1 for exactly 1 cycle with dm_addr=0x003; m0_ack pulses 2 cycles after req sampled; m1_ack stays 0.
- m1 reads addr 0x003 after the previous write → m1_rdata=0xDEADBEEF when m1_ack=1; m0_rdata is unchanged.
- FIXED_PRIO=0, both reqs held continuously from reset (m0 writes 0x001/0x11111111, m1 writes 0x002/0x22222222) → grant order 0,1,0,1; acks 3 cycles apart; memory words 1 and 2 hold the written values.
- FIXED_PRIO=1, both reqs held continuously → m0 acked every transaction, m1 never acked while m0 holds req; m1 is served on the first IDLE after m0 drops req.
- rst asserted for 1 cycle while in ACCESS on an m0 write of 0x00A/0x12345678 → word 0x00A unchanged, no ack, busy=0 the cycle after reset, rdata=0.
- m1 raises req during an m0 RESP cycle → m1 granted in the following transaction with no lost request; dm_we=0 in IDLE and RESP cycles throughout.
